// File: rtl/booth_pkg.sv
// Shared types and the Booth recoding helper for the sequential Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    typedef enum logic [1:0] {NOP, ADD, SUB} booth_op_t;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_m1}.
    function automatic booth_op_t booth_decode(input logic [1:0] bits);
        booth_op_t op;
        case (bits)
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of M into A, then an
// arithmetic right shift of {A, Q, q_m1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] q,
    input  logic         q_m1,
    input  logic [W-1:0] m,
    output logic [W-1:0] a_next,
    output logic [W-1:0] q_next,
    output logic         q_m1_next
);

    logic [W-1:0] sum;

    always_comb begin
        sum = a;
        case (booth_decode({q[0], q_m1}))
            ADD:     sum = a + m;
            SUB:     sum = a - m;
            default: sum = a;
        endcase
        a_next    = {sum[W-1], sum[W-1:1]};
        q_next    = {sum[0], q[W-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: N+1 steps per operation, signed or unsigned operands,
// start/busy/done handshake and a registered 2N-bit product.
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned W  = N + 1;
    localparam int unsigned CW = $clog2(W + 1);

    state_t           state_q, state_d;
    logic [W-1:0]     m_q, m_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   product_q, product_d;

    logic [W-1:0]     a_step;
    logic [W-1:0]     q_step;
    logic             qm1_step;

    booth_step #(
        .W (W)
    ) u_step (
        .a         (a_q),
        .q         (q_q),
        .q_m1      (qm1_q),
        .m         (m_q),
        .a_next    (a_step),
        .q_next    (q_step),
        .q_m1_next (qm1_step)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    // One extra bit keeps unsigned operands positive and A +/- M overflow-free.
                    m_d     = {signed_mode & multiplicand[N-1], multiplicand};
                    q_d     = {signed_mode & multiplier[N-1], multiplier};
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CW'(W);
                    state_d = ITER;
                end
            end
            ITER: begin
                a_d   = a_step;
                q_d   = q_step;
                qm1_d = qm1_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    product_d = {a_step[N-2:0], q_step};
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier at N=8, N=4 and N=16 with a product scoreboard.
module tb_booth_seq_multiplier;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        s8_start = 1'b0, s8_sm = 1'b0;
    logic [7:0]  s8_mc = '0, s8_mp = '0;
    logic        s8_busy, s8_done;
    logic [15:0] s8_prod;

    logic        s4_start = 1'b0, s4_sm = 1'b0;
    logic [3:0]  s4_mc = '0, s4_mp = '0;
    logic        s4_busy, s4_done;
    logic [7:0]  s4_prod;

    logic        s16_start = 1'b0, s16_sm = 1'b0;
    logic [15:0] s16_mc = '0, s16_mp = '0;
    logic        s16_busy, s16_done;
    logic [31:0] s16_prod;

    logic [15:0] sb8[$];
    logic [7:0]  sb4[$];
    logic [31:0] sb16[$];

    booth_seq_multiplier #(.N(8)) dut8 (
        .clk (clk), .rst (rst), .start (s8_start), .signed_mode (s8_sm),
        .multiplicand (s8_mc), .multiplier (s8_mp),
        .busy (s8_busy), .done (s8_done), .product (s8_prod)
    );

    booth_seq_multiplier #(.N(4)) dut4 (
        .clk (clk), .rst (rst), .start (s4_start), .signed_mode (s4_sm),
        .multiplicand (s4_mc), .multiplier (s4_mp),
        .busy (s4_busy), .done (s4_done), .product (s4_prod)
    );

    booth_seq_multiplier #(.N(16)) dut16 (
        .clk (clk), .rst (rst), .start (s16_start), .signed_mode (s16_sm),
        .multiplicand (s16_mc), .multiplier (s16_mp),
        .busy (s16_busy), .done (s16_done), .product (s16_prod)
    );

    // Reference products: extend per mode to 2N bits, keep the low 2N bits of the multiply.
    function automatic logic [15:0] ref8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea, eb;
        ea = {{8{sm & a[7]}}, a};
        eb = {{8{sm & b[7]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [7:0] ref4(input logic sm, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] ea, eb;
        ea = {{4{sm & a[3]}}, a};
        eb = {{4{sm & b[3]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] ref16(input logic sm, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [31:0] ea, eb;
        ea = {{16{sm & a[15]}}, a};
        eb = {{16{sm & b[15]}}, b};
        return ea * eb;
    endfunction

    // Runs one N=8 operation; lat is edges from acceptance to done (-1 on timeout).
    task automatic do_op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [15:0] prod, output int busy_cycles,
                          output logic done_after);
        @(negedge clk);
        s8_start = 1'b1; s8_sm = sm; s8_mc = a; s8_mp = b;
        sb8.push_back(ref8(sm, a, b));
        @(posedge clk);
        @(negedge clk);
        s8_start = 1'b0;
        busy_cycles = s8_busy ? 1 : 0;
        lat = -1;
        prod = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (s8_busy) busy_cycles++;
            if (s8_done) begin
                lat = k;
                prod = s8_prod;
                break;
            end
        end
        @(negedge clk);
        if (s8_busy) busy_cycles++;
        done_after = s8_done;
    endtask

    task automatic do_op4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                          output int lat, output logic [7:0] prod);
        @(negedge clk);
        s4_start = 1'b1; s4_sm = sm; s4_mc = a; s4_mp = b;
        sb4.push_back(ref4(sm, a, b));
        @(posedge clk);
        @(negedge clk);
        s4_start = 1'b0;
        lat = -1;
        prod = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (s4_done) begin
                lat = k;
                prod = s4_prod;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_op16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                           output int lat, output logic [31:0] prod);
        @(negedge clk);
        s16_start = 1'b1; s16_sm = sm; s16_mc = a; s16_mp = b;
        sb16.push_back(ref16(sm, a, b));
        @(posedge clk);
        @(negedge clk);
        s16_start = 1'b0;
        lat = -1;
        prod = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (s16_done) begin
                lat = k;
                prod = s16_prod;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (s8_busy !== 1'b0 || s8_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags8: busy=%b done=%b, required 0 0", s8_busy, s8_done);
        end
        checks++;
        if (s8_prod !== 16'h0000) begin
            errors++;
            $display("FAIL reset_product8: got %h, required 0000", s8_prod);
        end
        checks++;
        if (s4_busy !== 1'b0 || s16_busy !== 1'b0 || s4_prod !== 8'h00 || s16_prod !== 32'h0) begin
            errors++;
            $display("FAIL reset_other: busy4=%b busy16=%b prod4=%h prod16=%h, required zeros",
                     s4_busy, s16_busy, s4_prod, s16_prod);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_signed_basic();
        int lat, bc;
        logic [15:0] prod, exp;
        logic da;
        do_op8(1'b1, 8'h03, 8'hFB, lat, prod, bc, da);
        exp = sb8.pop_front();
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL basic_latency: got %0d, required 9", lat);
        end
        checks++;
        if (prod !== exp) begin
            errors++;
            $display("FAIL basic_scoreboard: got %h, required %h", prod, exp);
        end
        checks++;
        if (prod !== 16'hFFF1) begin
            errors++;
            $display("FAIL basic_value: got %h, required fff1", prod);
        end
        checks++;
        if (bc !== 10) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, required 10", bc);
        end
        checks++;
        if (da !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done after done cycle=%b, required 0", da);
        end
    endtask

    task automatic test_corners();
        logic        sm_t[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0]  a_t[4]  = '{8'hFF, 8'h80, 8'h80, 8'h00};
        logic [7:0]  b_t[4]  = '{8'hFF, 8'h80, 8'h7F, 8'hFF};
        logic [15:0] e_t[4]  = '{16'hFE01, 16'h4000, 16'hC080, 16'h0000};
        int lat, bc;
        logic [15:0] prod, exp;
        logic da;
        for (int i = 0; i < 4; i++) begin
            do_op8(sm_t[i], a_t[i], b_t[i], lat, prod, bc, da);
            exp = sb8.pop_front();
            checks++;
            if (prod !== e_t[i] || prod !== exp) begin
                errors++;
                $display("FAIL corner%0d: got %h, required %h (model %h)", i, prod, e_t[i], exp);
            end
            checks++;
            if (lat !== 9) begin
                errors++;
                $display("FAIL corner%0d_latency: got %0d, required 9", i, lat);
            end
        end
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        int late_busy = 0;
        int done_at = -1;
        logic [15:0] exp, got;
        got = '0;
        @(negedge clk);
        s8_start = 1'b1; s8_sm = 1'b1; s8_mc = 8'h07; s8_mp = 8'h06;
        sb8.push_back(ref8(1'b1, 8'h07, 8'h06));
        @(posedge clk);
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            if (s8_done) begin
                ndone++;
                done_at = k;
                got = s8_prod;
            end
            if (k >= 11 && s8_busy) late_busy++;
            // Keep start high through ITER and DONE with fresh operands; drop it in IDLE.
            if (k <= 9) begin
                s8_start = 1'b1;
                s8_sm = 1'($urandom_range(0, 1));
                s8_mc = 8'($urandom);
                s8_mp = 8'($urandom);
            end else begin
                s8_start = 1'b0;
            end
        end
        exp = sb8.pop_front();
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d, required 1", ndone);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL ignore_product: got %h, required %h", got, exp);
        end
        checks++;
        if (done_at !== 9) begin
            errors++;
            $display("FAIL ignore_latency: got %0d, required 9", done_at);
        end
        checks++;
        if (late_busy !== 0) begin
            errors++;
            $display("FAIL ignore_no_restart: busy seen %0d cycles after op, required 0", late_busy);
        end
    endtask

    task automatic test_mid_reset();
        int lat, bc;
        int ndone = 0;
        logic [15:0] prod, exp, dropped;
        logic da;
        @(negedge clk);
        s8_start = 1'b1; s8_sm = 1'b1; s8_mc = 8'h11; s8_mp = 8'h22;
        sb8.push_back(ref8(1'b1, 8'h11, 8'h22));
        @(posedge clk);
        @(negedge clk);
        s8_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (s8_busy !== 1'b1 || s8_prod === 16'h0000) begin
            errors++;
            $display("FAIL midrst_pre: busy=%b prod=%h, required busy 1 and prior nonzero product",
                     s8_busy, s8_prod);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (s8_busy !== 1'b0 || s8_done !== 1'b0 || s8_prod !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_async: busy=%b done=%b prod=%h, required 0 0 0000",
                     s8_busy, s8_done, s8_prod);
        end
        dropped = sb8.pop_back();
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (s8_done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL midrst_no_done: got %0d dones for abandoned op %h, required 0",
                     ndone, dropped);
        end
        do_op8(1'b0, 8'hC8, 8'h0B, lat, prod, bc, da);
        exp = sb8.pop_front();
        checks++;
        if (prod !== exp || prod !== 16'h0898) begin
            errors++;
            $display("FAIL midrst_fresh: got %h, required %h", prod, exp);
        end
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL midrst_fresh_latency: got %0d, required 9", lat);
        end
    endtask

    task automatic test_back_to_back();
        int gap = 0;
        int hold_bad = 0;
        logic seen = 1'b0;
        logic [15:0] first, exp;
        @(negedge clk);
        s8_start = 1'b1; s8_sm = 1'b1; s8_mc = 8'hF0; s8_mp = 8'h05;
        sb8.push_back(ref8(1'b1, 8'hF0, 8'h05));
        @(posedge clk);
        @(negedge clk);
        s8_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (s8_done) begin
                seen = 1'b1;
                break;
            end
        end
        first = s8_prod;
        exp = sb8.pop_front();
        checks++;
        if (!seen || first !== exp) begin
            errors++;
            $display("FAIL b2b_first: done=%b got %h, required %h", seen, first, exp);
        end
        @(negedge clk);
        gap = 1;
        s8_start = 1'b1; s8_sm = 1'b0; s8_mc = 8'h0C; s8_mp = 8'h0D;
        sb8.push_back(ref8(1'b0, 8'h0C, 8'h0D));
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            gap++;
            s8_start = 1'b0;
            if (s8_done) break;
            if (s8_prod !== first) hold_bad++;
        end
        exp = sb8.pop_front();
        checks++;
        if (gap !== 11) begin
            errors++;
            $display("FAIL b2b_gap: got %0d, required 11", gap);
        end
        checks++;
        if (hold_bad !== 0) begin
            errors++;
            $display("FAIL b2b_hold: product changed in %0d cycles, required 0", hold_bad);
        end
        checks++;
        if (s8_prod !== exp) begin
            errors++;
            $display("FAIL b2b_second: got %h, required %h", s8_prod, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep4();
        int lat;
        logic [7:0] prod, exp;
        logic sm;
        logic [3:0] a, b;
        for (int i = 0; i < 40; i++) begin
            sm = 1'(i % 2);
            a = 4'($urandom);
            b = 4'($urandom);
            do_op4(sm, a, b, lat, prod);
            exp = sb4.pop_front();
            checks++;
            if (prod !== exp) begin
                errors++;
                $display("FAIL sweep4_product: sm=%b %h*%h got %h, required %h", sm, a, b, prod, exp);
            end
            checks++;
            if (lat !== 5) begin
                errors++;
                $display("FAIL sweep4_latency: got %0d, required 5", lat);
            end
        end
    endtask

    task automatic test_sweep16();
        int lat;
        logic [31:0] prod, exp;
        logic sm;
        logic [15:0] a, b;
        for (int i = 0; i < 40; i++) begin
            sm = 1'(i % 2);
            a = (i == 0) ? 16'h8000 : 16'($urandom);
            b = (i == 1) ? 16'hFFFF : 16'($urandom);
            do_op16(sm, a, b, lat, prod);
            exp = sb16.pop_front();
            checks++;
            if (prod !== exp) begin
                errors++;
                $display("FAIL sweep16_product: sm=%b %h*%h got %h, required %h",
                         sm, a, b, prod, exp);
            end
            checks++;
            if (lat !== 17) begin
                errors++;
                $display("FAIL sweep16_latency: got %0d, required 17", lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_corners();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        test_sweep4();
        test_sweep16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
